eth_frame_builder: RTL and testbench
====================================

Name: eth_frame_builder

Overview:
Upstream stage of the 10BASE-T Manchester transmitter. Accepts a 484-byte UDP payload as a byte stream and builds a 526-byte Ethernet II / IPv4 / UDP frame into the shared 1024x8 frame BRAM through the BRAM write port. It computes the IPv4 header checksum, then requests transmission and holds off until the transmitter has drained the buffer. Single buffer: no BRAM writes while the transmitter is busy.

Parameters:
MAC_DST, 48'hFFFFFFFFFFFF, destination MAC
MAC_SRC, 48'h020000000001, source MAC
IP_SRC, 32'hC0A8010A, source IPv4 (192.168.1.10)
IP_DST, 32'hC0A80101, destination IPv4 (192.168.1.1)
UDP_SPORT, 16'd4000, UDP source port
UDP_DPORT, 16'd4000, UDP destination port
TTL, 8'd64, IPv4 TTL

Ports:
clk  in  1  system clock; same domain as the transmitter and BRAM
rst_n  in  1  asynchronous active-low reset
s_data  in  8  payload byte
s_valid  in  1  payload byte valid
s_ready  out  1  payload byte accepted when s_valid && s_ready
tx_start  out  1  transmit request to the transmitter
tx_busy  in  1  transmitter busy; high from first sampled start until its IPG ends
bram_wr_en  out  1  BRAM write strobe
bram_wr_addr  out  10  BRAM write address
bram_wr_data  out  8  BRAM write data
frame_count  out  16  frames handed to the transmitter; equals current IP ID

Behaviour:
- Reset (async, rst_n low): state IDLE. s_ready, tx_start, bram_wr_en = 0. bram_wr_addr, bram_wr_data = 0. frame_count/ip_id = 0. Checksum accumulator = 0.
- Reset mid-frame: the partial frame is discarded and tx_start is never issued for it.
- Fixed lengths (not parameters): payload 484, IP total length 16'h0200, UDP length 16'h01EC, frame 526 bytes at addresses 0..525.
- Header byte map, addresses 0..41:
  - 0-5 MAC_DST, 6-11 MAC_SRC, 12-13 0x0800
  - 14 0x45, 15 0x00, 16-17 0x0200, 18-19 ip_id, 20-21 0x4000, 22 TTL, 23 0x11, 24-25 ip_csum
  - 26-29 IP_SRC, 30-33 IP_DST, 34-35 UDP_SPORT, 36-37 UDP_DPORT, 38-39 0x01EC, 40-41 0x0000 (UDP checksum disabled)
  - All multi-byte fields are big-endian.
- States:
  - IDLE: if s_valid && !tx_busy, go to CSUM and clear the accumulator.
  - CSUM: 10 cycles. Adds the 10 IPv4 header 16-bit words into a 20-bit accumulator; the checksum word counts as 0.
  - FOLD: 2 cycles. f1 = acc[15:0] + acc[19:16]; then ip_csum = ~(f1[15:0] + f1[16]).
  - HDR: 42 cycles. bram_wr_en = 1 on every cycle. Address runs 0..41, data per the byte map.
  - PAYLOAD: s_ready = 1. Each accepted byte is written the same cycle (bram_wr_en = s_valid) at addresses 42..525. After the 484th accept, s_ready drops the next cycle and the state moves to START. Gaps in s_valid stall without error.
  - START: tx_start = 1 held as a level until tx_busy is sampled high, because the transmitter samples start only on its clk_en cycles. Then tx_start = 0 and go to WAIT.
  - WAIT: on tx_busy low, ip_id/frame_count increment (16-bit wrap, 0xFFFF -> 0x0000) and go to IDLE.
- bram_wr_en is 0 in every state except HDR and PAYLOAD. The address never exceeds 525.
- s_ready is 0 outside PAYLOAD, so payload is never consumed during checksum, header, or transmit.
- Latency from the IDLE trigger to the first header write: 12 cycles. The minimum frame build with no valid gaps is 12 + 42 + 484 = 538 cycles.

Test Plan:
- Reset, then a 484-byte stream 0x00..0xE3 wrapping mod 256 with s_valid always high -> BRAM[0..13] = FF×6, 02 00 00 00 00 01, 08 00; BRAM[24..25] = B5 91; BRAM[42] = 0x00, BRAM[525] = 0xE3; tx_start rises after the last write.
- Second frame after a transmitter model drops tx_busy -> frame_count = 1, BRAM[18..19] = 00 01, BRAM[24..25] = B5 90.
- s_valid toggling every other cycle in PAYLOAD -> exactly 484 writes, addresses contiguous 42..525, no write on s_valid = 0 cycles.
- tx_busy held high at the IDLE trigger -> no CSUM entry, s_ready = 0, no writes until tx_busy falls.
- Transmitter model with clk_en every 4th cycle -> tx_start held until tx_busy is sampled high; no BRAM write while tx_busy = 1.
- rst_n asserted at payload byte 100 -> all outputs 0 immediately (async); a new full frame then builds with ip_id = 0 and checksum B5 91.

Source files
------------

// File: rtl/eth_frame_builder.sv
// Builds a 526-byte Ethernet II/IPv4/UDP frame into the frame BRAM from a 484-byte payload stream.
// 12 cycles trigger-to-first-header-write; s_ready only in PAYLOAD, and no writes while the transmitter owns the buffer.
module eth_frame_builder #(
  parameter logic [47:0] MAC_DST   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] MAC_SRC   = 48'h020000000001,
  parameter logic [31:0] IP_SRC    = 32'hC0A8010A,
  parameter logic [31:0] IP_DST    = 32'hC0A80101,
  parameter logic [15:0] UDP_SPORT = 16'd4000,
  parameter logic [15:0] UDP_DPORT = 16'd4000,
  parameter logic [7:0]  TTL       = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bram_wr_en,
  output logic [9:0]  bram_wr_addr,
  output logic [7:0]  bram_wr_data,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, PAYLOAD, START, WAIT} state_t;

  state_t      state, state_nxt;
  logic [8:0]  cnt, cnt_nxt;
  logic [19:0] acc, acc_nxt;
  logic [16:0] f1, f1_nxt;
  logic [15:0] ip_csum, ip_csum_nxt;
  logic [15:0] ip_id, ip_id_nxt;
  logic [15:0] csum_word;
  logic [335:0] hdr_bits;
  logic [5:0]  hdr_idx;
  logic [7:0]  hdr_byte;

  assign frame_count = ip_id;

  // Header laid out MSB-first so byte 0 is the top octet of the vector.
  assign hdr_bits = {MAC_DST, MAC_SRC, 16'h0800, 8'h45, 8'h00, 16'h0200, ip_id,
                     16'h4000, TTL, 8'h11, ip_csum, IP_SRC, IP_DST,
                     UDP_SPORT, UDP_DPORT, 16'h01EC, 16'h0000};
  assign hdr_idx  = 6'd41 - cnt[5:0];
  assign hdr_byte = hdr_bits[{hdr_idx, 3'b000} +: 8];

  always_comb begin
    case (cnt[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = 16'h0200;
      4'd2:    csum_word = ip_id;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL, 8'h11};
      4'd6:    csum_word = IP_SRC[31:16];
      4'd7:    csum_word = IP_SRC[15:0];
      4'd8:    csum_word = IP_DST[31:16];
      4'd9:    csum_word = IP_DST[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      f1      <= '0;
      ip_csum <= '0;
      ip_id   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      f1      <= f1_nxt;
      ip_csum <= ip_csum_nxt;
      ip_id   <= ip_id_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    f1_nxt       = f1;
    ip_csum_nxt  = ip_csum;
    ip_id_nxt    = ip_id;
    s_ready      = 1'b0;
    tx_start     = 1'b0;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    case (state)
      IDLE: begin
        if (s_valid && !tx_busy) begin
          state_nxt = CSUM;
          cnt_nxt   = '0;
          acc_nxt   = '0;
        end
      end
      CSUM: begin
        acc_nxt = acc + {4'b0, csum_word};
        if (cnt == 9'd9) begin
          state_nxt = FOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      FOLD: begin
        if (cnt == 9'd0) begin
          f1_nxt  = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
          cnt_nxt = 9'd1;
        end else begin
          ip_csum_nxt = ~(f1[15:0] + {15'b0, f1[16]});
          state_nxt   = HDR;
          cnt_nxt     = '0;
        end
      end
      HDR: begin
        bram_wr_en   = 1'b1;
        bram_wr_addr = {4'b0, cnt[5:0]};
        bram_wr_data = hdr_byte;
        if (cnt == 9'd41) begin
          state_nxt = PAYLOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      PAYLOAD: begin
        s_ready    = 1'b1;
        bram_wr_en = s_valid;
        if (s_valid) begin
          bram_wr_addr = 10'd42 + {1'b0, cnt};
          bram_wr_data = s_data;
          if (cnt == 9'd483) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 9'd1;
          end
        end
      end
      START: begin
        // Held as a level: the transmitter only samples it on its enable cycles.
        tx_start = 1'b1;
        if (tx_busy) state_nxt = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          ip_id_nxt = ip_id + 16'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// Randomized scoreboard bench for eth_frame_builder with a slow-enable transmitter model.
module tb_eth_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx_start;
  logic        tx_busy;
  logic        bram_wr_en;
  logic [9:0]  bram_wr_addr;
  logic [7:0]  bram_wr_data;
  logic [15:0] frame_count;

  eth_frame_builder dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_start(tx_start), .tx_busy(tx_busy), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  mem [1024];
  logic [7:0]  hdr [42];
  logic [7:0]  pay [484];
  logic [15:0] exp_id = 16'd0;
  int          tests = 0;
  int          fails = 0;

  bit force_busy = 1'b0;
  int clk_en_div = 1;
  int busy_len   = 20;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic put_be(input int at, input logic [47:0] v, input int n);
    for (int k = 0; k < n; k++) hdr[at + k] = 8'(v >> (8 * (n - 1 - k)));
  endtask

  // Reference frame: header from the field list, checksum by one's-complement sum, then payload.
  task automatic build_frame(input int mode);
    logic [31:0] sum;
    wr_t w;
    for (int i = 0; i < 484; i++) pay[i] = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
    put_be(0, 48'hFFFFFFFFFFFF, 6);
    put_be(6, 48'h020000000001, 6);
    put_be(12, 48'h0800, 2);
    hdr[14] = 8'h45;
    hdr[15] = 8'h00;
    put_be(16, 48'd512, 2);
    put_be(18, {32'h0, exp_id}, 2);
    put_be(20, 48'h4000, 2);
    hdr[22] = 8'd64;
    hdr[23] = 8'd17;
    put_be(24, 48'h0, 2);
    put_be(26, 48'hC0A8010A, 4);
    put_be(30, 48'hC0A80101, 4);
    put_be(34, 48'd4000, 2);
    put_be(36, 48'd4000, 2);
    put_be(38, 48'd492, 2);
    put_be(40, 48'h0, 2);
    sum = 32'h0;
    for (int k = 14; k < 34; k += 2) sum += {16'h0, hdr[k], hdr[k + 1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    hdr[24] = ~sum[15:8];
    hdr[25] = ~sum[7:0];
    for (int i = 0; i < 42; i++) begin
      w.addr = 10'(i); w.data = hdr[i]; exp_q.push_back(w);
    end
    for (int i = 0; i < 484; i++) begin
      w.addr = 10'(42 + i); w.data = pay[i]; exp_q.push_back(w);
    end
  endtask

  // Offers pay[] byte by byte; gap toggles s_valid every cycle; abort_at pulls reset after that many accepts.
  task automatic send_frame(input bit gap, input int abort_at);
    int accepted = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (accepted < 484 && cyc < 4000) begin
      if (abort_at >= 0 && accepted == abort_at) begin
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        return;
      end
      s_valid = gap ? tog : 1'b1;
      tog     = !tog;
      s_data  = pay[accepted];
      @(negedge clk);
      if (s_valid && s_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    check(accepted == 484, "payload_accept_count", accepted, 484);
  endtask

  task automatic wait_done();
    logic [15:0] nxt = exp_id + 16'd1;
    int c = 0;
    while (frame_count != nxt && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    check(frame_count == nxt, "frame_count", frame_count, nxt);
    check(exp_q.size() == 0, "writes_remaining", exp_q.size(), 0);
    exp_id = nxt;
  endtask

  task automatic check_zero(input string tag);
    check(s_ready == 1'b0, {tag, "_s_ready"}, s_ready, 0);
    check(tx_start == 1'b0, {tag, "_tx_start"}, tx_start, 0);
    check(bram_wr_en == 1'b0, {tag, "_wr_en"}, bram_wr_en, 0);
    check(bram_wr_addr == 10'd0, {tag, "_wr_addr"}, bram_wr_addr, 0);
    check(bram_wr_data == 8'd0, {tag, "_wr_data"}, bram_wr_data, 0);
    check(frame_count == 16'd0, {tag, "_frame_count"}, frame_count, 0);
  endtask

  // Transmitter: samples start on every clk_en_div-th cycle, then stays busy for busy_len cycles.
  initial begin
    int phase = 0;
    int busy_left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      phase++;
      if (!rst_n) begin
        tx_busy = 1'b0; busy_left = 0;
      end else if (force_busy) begin
        tx_busy = 1'b1; busy_left = 0;
      end else if (tx_busy) begin
        if (busy_left == 0) tx_busy = 1'b0;
        else busy_left--;
      end else if (tx_start && (phase % clk_en_div) == 0) begin
        tx_busy = 1'b1; busy_left = busy_len;
      end
    end
  end

  // Monitor: every BRAM write is matched in order against the scoreboard queue.
  initial begin
    bit prev_start = 1'b0;
    bit prev_busy  = 1'b0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bram_wr_en) begin
          mem[bram_wr_addr] = bram_wr_data;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", {12'h0, bram_wr_addr, bram_wr_data}, 0);
          end else begin
            e = exp_q.pop_front();
            check(bram_wr_addr == e.addr && bram_wr_data == e.data, "bram_write",
                  {12'h0, bram_wr_addr, bram_wr_data}, {12'h0, e.addr, e.data});
          end
          check(!tx_busy, "write_while_busy", tx_busy, 0);
          if (bram_wr_addr >= 10'd42) check(s_valid && s_ready, "payload_write_handshake", {s_valid, s_ready}, 2'b11);
        end
        if (tx_start && !prev_start) check(exp_q.size() == 0, "start_after_last_write", exp_q.size(), 0);
        if (prev_start && !prev_busy && !tx_start) check(1'b0, "start_dropped_early", tx_start, 1);
        prev_start = tx_start;
        prev_busy  = tx_busy;
      end else begin
        prev_start = 1'b0;
        prev_busy  = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    rst_n   = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Frame 1: incrementing payload, continuous valid.
    build_frame(0);
    send_frame(1'b0, -1);
    wait_done();
    for (int i = 0; i < 6; i++) check(mem[i] == 8'hFF, "mac_dst", mem[i], 8'hFF);
    check({mem[6], mem[7], mem[8], mem[9], mem[10], mem[11]} == 48'h020000000001, "mac_src",
          {mem[8], mem[9], mem[10], mem[11]}, 32'h00000001);
    check({mem[12], mem[13]} == 16'h0800, "ethertype", {mem[12], mem[13]}, 16'h0800);
    check({mem[24], mem[25]} == 16'hB591, "ip_csum_id0", {mem[24], mem[25]}, 16'hB591);
    check(mem[42] == 8'h00, "first_payload", mem[42], 8'h00);
    check(mem[525] == 8'hE3, "last_payload", mem[525], 8'hE3);

    // Frame 2: random payload, ip_id 1.
    build_frame(1);
    send_frame(1'b0, -1);
    wait_done();
    check({mem[18], mem[19]} == 16'h0001, "ip_id_1", {mem[18], mem[19]}, 16'h0001);
    check({mem[24], mem[25]} == 16'hB590, "ip_csum_id1", {mem[24], mem[25]}, 16'hB590);

    // Frame 3: s_valid toggling every cycle.
    build_frame(1);
    send_frame(1'b1, -1);
    wait_done();

    // Transmitter busy at the trigger: nothing may start.
    build_frame(1);
    force_busy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check(!s_ready && !bram_wr_en, "busy_hold_idle", {s_ready, bram_wr_en}, 0);
    end
    check(exp_q.size() == 526, "busy_hold_no_writes", exp_q.size(), 526);
    @(posedge clk); #1;
    force_busy = 1'b0;
    clk_en_div = 4;
    busy_len   = 30;
    send_frame(1'b0, -1);
    wait_done();

    // Reset at payload byte 100, then a clean frame with ip_id restarted.
    build_frame(1);
    send_frame(1'b0, 100);
    #1;
    check_zero("midframe_reset");
    exp_q.delete();
    exp_id = 16'd0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_frame(0);
    send_frame(1'b0, -1);
    wait_done();
    check({mem[18], mem[19]} == 16'h0000, "ip_id_after_reset", {mem[18], mem[19]}, 16'h0000);
    check({mem[24], mem[25]} == 16'hB591, "ip_csum_after_reset", {mem[24], mem[25]}, 16'hB591);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
